// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: FSM states and read-owner codes.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VGA_PRI = 2'd1,
        CPU_PRI = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_e;

    // Wide enough for any legal MAX_WAIT (up to 255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/vram_owner_pipe.sv
// Tracks which requester owns each read in flight, RD_LAT stages deep,
// so returning RAM data can be steered to the right port.
module vram_owner_pipe
    import vram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] owner_in,
    output logic [1:0] owner_out
);

    logic [1:0] stage [RD_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= owner_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign owner_out = stage[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between a CPU (read/write) and a VGA scanout (read-only).
// Define VRAM_ARB_FAIRNESS_EN to add the CPU starvation counter and CPU_PRI state.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    if ((RD_LAT < 1) || (RD_LAT > 4) || (MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_param_check
        $error("vram_arbiter: RD_LAT or MAX_WAIT out of range");
    end

    state_e            state, state_next;
    logic              any_req;
    logic              cpu_pri;
    logic [1:0]        owner_in, owner_out;
    logic [DATA_W-1:0] cpu_rdata_q, vga_rdata_q;

    assign any_req = cpu_req | vga_req;

    // Grants are gated by reset so nothing reaches the RAM while it is held.
    always_comb begin
        cpu_gnt = 1'b0;
        vga_gnt = 1'b0;
        if (reset) begin
            if (cpu_pri) begin
                cpu_gnt = cpu_req;
                vga_gnt = vga_req & ~cpu_req;
            end else begin
                vga_gnt = vga_req;
                cpu_gnt = cpu_req & ~vga_req;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        owner_in  = OWN_NONE;
        if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we;
            owner_in  = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (vga_gnt) begin
            ram_addr  = vga_addr;
            owner_in  = OWN_VGA;
        end
    end

`ifdef VRAM_ARB_FAIRNESS_EN
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt, wait_next;

    always_comb begin
        wait_next = '0;
        if (cpu_req && !cpu_gnt) begin
            wait_next = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_next;
        end
    end

    assign cpu_pri = (state == CPU_PRI);
`else
    assign cpu_pri = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The limit is checked against the count including this cycle's miss,
    // so after MAX_WAIT lost cycles the CPU wins the very next one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) state_next = VGA_PRI;
            end
            VGA_PRI: begin
                if (!any_req) state_next = IDLE;
`ifdef VRAM_ARB_FAIRNESS_EN
                else if (wait_next == WAIT_LIMIT) state_next = CPU_PRI;
`endif
            end
`ifdef VRAM_ARB_FAIRNESS_EN
            CPU_PRI: begin
                if (!any_req) state_next = IDLE;
                else if (cpu_gnt) state_next = VGA_PRI;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    vram_owner_pipe #(
        .RD_LAT (RD_LAT)
    ) u_owner_pipe (
        .clk       (clk),
        .reset     (reset),
        .owner_in  (owner_in),
        .owner_out (owner_out)
    );

    assign cpu_rvalid = (owner_out == OWN_CPU);
    assign vga_rvalid = (owner_out == OWN_VGA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
            if (vga_rvalid) vga_rdata_q <= ram_rdata;
        end
    end

    // Returned data appears in the rvalid cycle itself, then is held.
    assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
    assign vga_rdata = vga_rvalid ? ram_rdata : vga_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed, table-driven bench for vram_arbiter with a behavioural RAM model (RD_LAT=2).
module tb_vram_arbiter;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 8;
`ifdef VRAM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, vga_req;
    logic [ADDR_W-1:0] cpu_addr, vga_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, ram_we;
    logic [DATA_W-1:0] cpu_rdata, vga_rdata, ram_wdata, ram_rdata;
    logic [ADDR_W-1:0] ram_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    // Behavioural RAM: data for an address shows up RD_LAT cycles after issue.
    logic [DATA_W-1:0] mem [8] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hDEADBEEF,
                                   32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
    logic [ADDR_W-1:0] raddr_pipe [RD_LAT] = '{default: '0};

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        raddr_pipe[0] <= ram_addr;
        for (int i = 1; i < RD_LAT; i++) raddr_pipe[i] <= raddr_pipe[i-1];
    end

    assign ram_rdata = mem[raddr_pipe[RD_LAT-1]];

    typedef struct {
        logic              cpu_req;
        logic              cpu_we;
        logic [ADDR_W-1:0] cpu_addr;
        logic [DATA_W-1:0] cpu_wdata;
        logic              vga_req;
        logic [ADDR_W-1:0] vga_addr;
        logic              exp_cpu_gnt;
        logic              exp_vga_gnt;
        logic              exp_ram_we;
        logic [ADDR_W-1:0] exp_ram_addr;
        logic [DATA_W-1:0] exp_ram_wdata;
        logic              exp_cpu_rvalid;
        logic              exp_vga_rvalid;
        logic [DATA_W-1:0] exp_cpu_rdata;
        logic [DATA_W-1:0] exp_vga_rdata;
    } vec_t;

    vec_t vecs [16];

    task automatic applyStimulus(input logic c_req, input logic c_we, input logic [ADDR_W-1:0] c_addr,
                                 input logic [DATA_W-1:0] c_wdata, input logic v_req,
                                 input logic [ADDR_W-1:0] v_addr);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        vga_req   = v_req;
        vga_addr  = v_addr;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Vector fields: cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr,
        // exp cpu_gnt, vga_gnt, ram_we, ram_addr, ram_wdata, cpu_rvalid, vga_rvalid, cpu_rdata, vga_rdata
        vecs[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h0,        32'h0};
        vecs[1]  = '{1, 0, 3, 0, 0, 0,  1, 0, 0, 3, 0,  0, 0, 32'h0,        32'h0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h0,        32'h0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1, 0, 1, 0, 1, 5,  0, 1, 0, 5, 0,  0, 0, 32'hDEADBEEF, 32'h0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 32'hDEADBEEF, 32'hC0DE0005};
        vecs[8]  = '{1, 1, 2, 5, 0, 0,  1, 0, 1, 2, 5,  0, 0, 32'hDEADBEEF, 32'hC0DE0005};
        vecs[9]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'hDEADBEEF, 32'hC0DE0005};
        vecs[10] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'hDEADBEEF, 32'hC0DE0005};
        vecs[11] = '{1, 0, 2, 0, 0, 0,  1, 0, 0, 2, 0,  0, 0, 32'hDEADBEEF, 32'hC0DE0005};
        vecs[12] = '{0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 32'hDEADBEEF, 32'hC0DE0005};
        vecs[13] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 32'h5,        32'hC0DE0005};
        vecs[14] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 32'h5,        32'hC0DE0000};
        vecs[15] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h5,        32'hC0DE0000};

        // Reset state, with requests asserted to show grants are suppressed.
        reset = 1'b0;
        applyStimulus(1, 1, 3, 32'h1234, 1, 4);
        @(negedge clk);
        checkOutput("reset_gnt", 64'({cpu_gnt, vga_gnt}), 64'b00);
        checkOutput("reset_ram", 64'({ram_we, ram_addr, ram_wdata}), 64'h0);
        checkOutput("reset_ret", 64'({cpu_rvalid, vga_rvalid, cpu_rdata}), 64'h0);
        checkOutput("reset_vga_rdata", 64'(vga_rdata), 64'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        for (int v = 0; v < 16; v++) begin
            applyStimulus(vecs[v].cpu_req, vecs[v].cpu_we, vecs[v].cpu_addr, vecs[v].cpu_wdata,
                          vecs[v].vga_req, vecs[v].vga_addr);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_gnt", v), 64'({cpu_gnt, vga_gnt}),
                        64'({vecs[v].exp_cpu_gnt, vecs[v].exp_vga_gnt}));
            checkOutput($sformatf("vec%0d_ram", v), 64'({ram_we, ram_addr, ram_wdata}),
                        64'({vecs[v].exp_ram_we, vecs[v].exp_ram_addr, vecs[v].exp_ram_wdata}));
            checkOutput($sformatf("vec%0d_cpu_ret", v), 64'({cpu_rvalid, cpu_rdata}),
                        64'({vecs[v].exp_cpu_rvalid, vecs[v].exp_cpu_rdata}));
            checkOutput($sformatf("vec%0d_vga_ret", v), 64'({vga_rvalid, vga_rdata}),
                        64'({vecs[v].exp_vga_rvalid, vecs[v].exp_vga_rdata}));
            nextCycle();
        end

        // Four back-to-back VGA reads of addresses 4..7; returns arrive in order.
        for (int k = 0; k < 7; k++) begin
            logic [DATA_W-1:0] exp_data;
            applyStimulus(0, 0, 0, 0, (k < 4), 3'(4 + k));
            exp_data = (k < 2) ? 32'hC0DE0000 : ((k > 5) ? 32'hC0DE0007 : 32'hC0DE0004 + 32'(k - 2));
            @(negedge clk);
            checkOutput($sformatf("b2b%0d_gnt", k), 64'({cpu_gnt, vga_gnt}), 64'({1'b0, k < 4}));
            checkOutput($sformatf("b2b%0d_ret", k), 64'({vga_rvalid, vga_rdata}),
                        64'({(k >= 2) && (k <= 5), exp_data}));
            nextCycle();
        end

        // Both requesters held: CPU wins on cycles 9 and 18 only when fairness is built in.
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        for (int c = 1; c <= 20; c++) begin
            logic exp_cpu;
            applyStimulus(1, 0, 1, 0, 1, 6);
            exp_cpu = FAIR && ((c == 9) || (c == 18));
            @(negedge clk);
            checkOutput($sformatf("starve%0d_gnt", c), 64'({cpu_gnt, vga_gnt}), 64'({exp_cpu, ~exp_cpu}));
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) nextCycle();

        // Reset pulled one cycle after a CPU read grant: the read must vanish.
        applyStimulus(1, 0, 3, 0, 0, 0);
        @(negedge clk);
        checkOutput("rstmid_grant", 64'({cpu_gnt, vga_gnt, ram_addr}), 64'({2'b10, 3'd3}));
        nextCycle();
        reset = 1'b0;
        applyStimulus(1, 1, 2, 32'hFFFF, 1, 7);
        @(negedge clk);
        checkOutput("rstmid_gnt", 64'({cpu_gnt, vga_gnt}), 64'b00);
        checkOutput("rstmid_ram", 64'({ram_we, ram_addr, ram_wdata}), 64'h0);
        checkOutput("rstmid_cpu_ret", 64'({cpu_rvalid, cpu_rdata}), 64'h0);
        checkOutput("rstmid_vga_ret", 64'({vga_rvalid, vga_rdata}), 64'h0);
        nextCycle();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("postrst%0d_ret", k),
                        64'({cpu_rvalid, vga_rvalid, cpu_rdata}), 64'h0);
            nextCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3: RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter RD_LAT, default 1: RAM read latency in cycles, legal range 1..4.
REQ-004 SHALL have parameter MAX_WAIT, default 8: CPU starvation limit in cycles, legal range 1..255.
REQ-005 SHALL have ports `clk` (in, 1, system clock) and `reset` (in, 1, asynchronous, active-low).
REQ-006 SHALL have CPU-side ports:
- `cpu_req` (in, 1, access request)
- `cpu_we` (in, 1, write request)
- `cpu_addr` (in, ADDR_W)
- `cpu_wdata` (in, DATA_W)
REQ-007 SHALL have CPU-side returns:
- `cpu_gnt` (out, 1, request accepted this cycle)
- `cpu_rvalid` (out, 1, read data valid)
- `cpu_rdata` (out, DATA_W)
REQ-008 SHALL have VGA-side ports (read-only):
- `vga_req` (in, 1)
- `vga_addr` (in, ADDR_W)
- `vga_gnt` (out, 1)
- `vga_rvalid` (out, 1)
- `vga_rdata` (out, DATA_W)
REQ-009 SHALL have RAM-side ports:
- `ram_addr` (out, ADDR_W)
- `ram_wdata` (out, DATA_W)
- `ram_we` (out, 1)
- `ram_rdata` (in, DATA_W, valid RD_LAT cycles after address issue)

Function
REQ-010 SHALL grant at most one requester per cycle; grant is combinational from requests and the current state.
REQ-011 SHALL drive `ram_addr`, `ram_we` and `ram_wdata` from the granted requester in the grant cycle. With no grant: `ram_we`=0, `ram_addr`=0 and `ram_wdata`=0.
REQ-012 SHALL implement the state machine with states IDLE, VGA_PRI and CPU_PRI:
- IDLE→VGA_PRI on any request.
- VGA_PRI→CPU_PRI when the wait counter equals MAX_WAIT.
- CPU_PRI→VGA_PRI after exactly one CPU grant.
- VGA_PRI or CPU_PRI→IDLE when no request is present.
REQ-013 SHALL give VGA fixed priority in IDLE and VGA_PRI; in CPU_PRI, SHALL give priority to the CPU.
REQ-014 SHALL count consecutive cycles with `cpu_req`=1 and `cpu_gnt`=0, saturating at MAX_WAIT. The counter clears on `cpu_gnt` or when `cpu_req`=0.
REQ-015 SHALL treat a request as held by the requester until granted; it SHALL NOT register ungranted requests.
REQ-016 SHALL track each issued read in an RD_LAT-deep owner pipeline. `cpu_rvalid` or `vga_rvalid` SHALL pulse exactly RD_LAT cycles after the grant, with the corresponding rdata equal to `ram_rdata`.
REQ-017 SHALL generate no rvalid for CPU writes.
REQ-018 SHALL sustain back-to-back grants, one per cycle, with in-flight reads returned in issue order.
REQ-019 SHALL hold `cpu_rdata` and `vga_rdata` at their last returned value when rvalid=0.
REQ-020 SHALL grant VGA when `cpu_req` and `vga_req` are asserted simultaneously in IDLE.

Reset
REQ-021 SHALL, while `reset`=0, force:
- state to IDLE
- wait counter to 0
- owner pipeline to empty
- all gnt, rvalid and `ram_we` outputs to 0
- rdata outputs to 0
REQ-022 SHALL discard reads in flight when reset asserts mid-operation; no rvalid is produced for them after release.

Configuration
REQ-023 SHALL, with macro VRAM_ARB_FAIRNESS_EN defined, implement the wait counter and the CPU_PRI state as specified.
REQ-024 SHALL, with VRAM_ARB_FAIRNESS_EN undefined, omit the counter and CPU_PRI. Arbitration is then strict VGA priority, and CPU starvation is permitted.

Structure
REQ-025 SHALL place the state enum (IDLE, VGA_PRI, CPU_PRI) and the owner encoding (OWN_NONE, OWN_CPU, OWN_VGA) in shared package vram_pkg.
REQ-026 SHALL implement the owner pipeline as sub-module vram_owner_pipe, parameterised by RD_LAT.

Verification
REQ-027 SHALL cover single CPU read: `cpu_req`=1, `cpu_addr`=3, `ram_rdata`=0xDEADBEEF → `cpu_gnt` asserts the same cycle; `cpu_rvalid`=1 with `cpu_rdata`=0xDEADBEEF RD_LAT cycles later.
REQ-028 SHALL cover simultaneous requests in IDLE: both requests asserted → `vga_gnt`=1 and `cpu_gnt`=0 that cycle.
REQ-029 SHALL cover starvation with FAIRNESS_EN and MAX_WAIT=8: `vga_req` and `cpu_req` held high → `cpu_gnt` asserts on the 9th cycle, followed by a return to VGA grants.
REQ-030 SHALL cover CPU write: `cpu_we`=1, addr 2, data 0x5 → `ram_we`=1, `ram_addr`=2, `ram_wdata`=5 for one cycle; `cpu_rvalid` stays 0.
REQ-031 SHALL cover back-to-back reads: 4 consecutive VGA reads with RD_LAT=2 → 4 consecutive `vga_rvalid` pulses in issue order.
REQ-032 SHALL cover reset mid-read: `reset` pulled to 0 one cycle after a read grant → no rvalid ever appears; all outputs are 0 during reset.
